// File: rtl/data_bus_arbiter_if.sv
// Bundle of both master ports and the shared slave port of the data bus arbiter.
// The slave modport is the arbiter's own view. The master modport is the view of
// the surrounding system: the two requesters, the slave device and the core lock.
interface data_bus_arbiter_if;

   // Master 0 (core data port)
   logic        m0_req;
   logic        m0_we;
   logic [3:0]  m0_be;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m0_lock;

   // Master 1 (DMA / debug loader)
   logic        m1_req;
   logic        m1_we;
   logic [3:0]  m1_be;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_rvalid;
   logic [31:0] m1_rdata;
   logic        m1_err;

   // Shared slave port
   logic        slv_req;
   logic        slv_we;
   logic [3:0]  slv_be;
   logic [31:0] slv_addr;
   logic [31:0] slv_wdata;
   logic [31:0] slv_rdata;

   modport slave (
      input  m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_lock,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata, m1_err,
      output slv_req, slv_we, slv_be, slv_addr, slv_wdata,
      input  slv_rdata
   );

   modport master (
      output m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_lock,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
      input  slv_req, slv_we, slv_be, slv_addr, slv_wdata,
      output slv_rdata
   );

endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared RAM / peripheral data bus.
// One transfer in flight at a time: IDLE (grant) -> ACCESS (slave req) -> RESP (rvalid).
// Master 0 can lock the bus across consecutive transfers; master 1 is filtered per
// peripheral index by M1_ALLOW and receives an error response when refused.
module data_bus_arbiter #(
   parameter logic [7:0] M1_ALLOW = 8'h61
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   data_bus_arbiter_if.slave   bus_io
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } state_e;

   state_e      state_q;
   logic        owner_q;     // master owning the transfer in flight
   logic        last_q;      // owner of the most recently completed transfer
   logic        locked_q;    // master 0 holds the bus
   logic        deny_q;      // current transfer refused, no slave access

   // Command latch
   logic        cmd_we_q;
   logic [3:0]  cmd_be_q;
   logic [31:0] cmd_addr_q;
   logic [31:0] cmd_wdata_q;

   // Registered pulse outputs
   logic        slv_req_q;
   logic        m0_rvalid_q;
   logic        m1_rvalid_q;
   logic        m1_err_q;

   // Winner selection and its command
   logic        win_valid;
   logic        win_id;
   logic        win_we;
   logic [3:0]  win_be;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;
   logic        win_deny;
   logic        take;
   logic [31:0] resp_data;

   // Pick the winner among current requests; a held lock shuts master 1 out entirely.
   always_comb begin
      win_valid = 1'b0;
      win_id    = 1'b0;
      if (locked_q) begin
         win_valid = bus_io.m0_req;
         win_id    = 1'b0;
      end else if (bus_io.m0_req && bus_io.m1_req) begin
         win_valid = 1'b1;
         win_id    = ~last_q;
      end else if (bus_io.m0_req) begin
         win_valid = 1'b1;
         win_id    = 1'b0;
      end else if (bus_io.m1_req) begin
         win_valid = 1'b1;
         win_id    = 1'b1;
      end
   end

   // Route the winner's command and classify it against the master 1 access mask.
   always_comb begin
      win_we    = win_id ? bus_io.m1_we    : bus_io.m0_we;
      win_be    = win_id ? bus_io.m1_be    : bus_io.m0_be;
      win_addr  = win_id ? bus_io.m1_addr  : bus_io.m0_addr;
      win_wdata = win_id ? bus_io.m1_wdata : bus_io.m0_wdata;
      // Peripheral indices 8..255 are never reachable from master 1.
      win_deny  = win_id & ((|win_addr[31:27]) | ~M1_ALLOW[win_addr[26:24]]);
   end

   // Grant is combinational in IDLE and suppressed while reset is held.
   assign take           = (state_q == StIdle) && win_valid && rst_n_i;
   assign bus_io.m0_gnt  = take & ~win_id;
   assign bus_io.m1_gnt  = take &  win_id;

   // Transfer sequencer: latches the command, drives the slave and issues the response.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         locked_q    <= 1'b0;
         deny_q      <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_be_q    <= '0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         slv_req_q   <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m1_err_q    <= 1'b0;
      end else begin
         slv_req_q   <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m1_err_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (take) begin
                  owner_q     <= win_id;
                  deny_q      <= win_deny;
                  cmd_we_q    <= win_we;
                  cmd_be_q    <= win_be;
                  cmd_addr_q  <= win_addr;
                  cmd_wdata_q <= win_wdata;
                  slv_req_q   <= ~win_deny;
                  state_q     <= StAccess;
               end
            end
            StAccess: begin
               m0_rvalid_q <= ~owner_q;
               m1_rvalid_q <=  owner_q;
               m1_err_q    <=  owner_q & deny_q;
               state_q     <= StResp;
            end
            StResp: begin
               last_q   <= owner_q;
               // Lock is only picked up or released at the end of a master 0 transfer.
               locked_q <= ~owner_q & bus_io.m0_lock;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Slave side always reflects the latch; only the request strobe is qualified.
   assign bus_io.slv_req   = slv_req_q;
   assign bus_io.slv_we    = cmd_we_q;
   assign bus_io.slv_be    = cmd_be_q;
   assign bus_io.slv_addr  = cmd_addr_q;
   assign bus_io.slv_wdata = cmd_wdata_q;

   // Read data passes through only for a real (non-denied) read, and only to the owner.
   assign resp_data        = (deny_q || cmd_we_q) ? 32'h0 : bus_io.slv_rdata;
   assign bus_io.m0_rvalid = m0_rvalid_q;
   assign bus_io.m1_rvalid = m1_rvalid_q;
   assign bus_io.m0_rdata  = m0_rvalid_q ? resp_data : 32'h0;
   assign bus_io.m1_rdata  = m1_rvalid_q ? resp_data : 32'h0;
   assign bus_io.m1_err    = m1_err_q;

   // Structural sanity: never two grants, never two responses.
   a_one_gnt : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(bus_io.m0_gnt && bus_io.m1_gnt));
   a_one_rvalid : assert property (@(posedge clk_i) disable iff (!rst_n_i)
      !(bus_io.m0_rvalid && bus_io.m1_rvalid));

endmodule
